// File: rtl/enet_pkg.sv
// Shared types and constants for the DM9000A register-level bus controller.
// No logic; constants only.
// Imported by the controller and its cycle timer.
package enet_pkg;

  // Post-command delay codes. Any code at or above LONG_DELAY selects the long delay.
  localparam logic [2:0] NO_DELAY   = 3'd0;
  localparam logic [2:0] STD_DELAY  = 3'd1;
  localparam logic [2:0] LONG_DELAY = 3'd2;

  // Levels on the DM9000A CMD pin.
  localparam logic INDEX = 1'b0;
  localparam logic DATA  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    IDX_SETUP,
    IDX_PULSE,
    IDX_HOLD,
    DAT_SETUP,
    DAT_PULSE,
    DAT_HOLD,
    POST_DELAY
  } bus_state_e;

  // A command, captured as a single unit when it is accepted.
  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] dataw;
    logic        write;
    logic [2:0]  dly;
  } cmd_t;

endpackage

// File: rtl/enet_cycle_timer.sv
// Loadable 16-bit down-counter with a done flag. It times setup, pulse and post-delay phases.
// Latency: done_o is high in the cycle where the count reaches zero, which is load_val_i cycles after the load.
// Backpressure: none. A load always wins over counting, and the count holds at zero.
module enet_cycle_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic        done_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: a load takes priority; otherwise count down and stop at zero without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 16'd0);

endmodule

// File: rtl/enet_bus_controller.sv
// DM9000A register access. Each command becomes an index cycle followed by a data cycle, then an optional hold-off.
// Latency: 2*(SETUP_CYCLES+PULSE_CYCLES+1) cycles plus the selected delay, counted from the accept edge to rdy_out.
// Backpressure: start_comm_in is honoured only while rdy_out=1. Otherwise it is dropped and nothing is queued.
module enet_bus_controller
  import enet_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES      = 1,
  parameter int unsigned PULSE_CYCLES      = 2,
  parameter int unsigned STD_DELAY_CYCLES  = 16,
  parameter int unsigned LONG_DELAY_CYCLES = 50000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        start_comm_in,
  input  logic [7:0]  addr_in,
  input  logic [15:0] dataw_in,
  input  logic        write_in,
  input  logic [2:0]  post_command_delay_in,
  output logic        rdy_out,
  output logic [15:0] datar_out,
  output logic        datar_valid_out,
  input  logic [15:0] enet_data_in,
  output logic [15:0] enet_data_out,
  output logic        enet_data_oe,
  output logic        enet_cmd_out,
  output logic        enet_cs_n_out,
  output logic        enet_iow_n_out,
  output logic        enet_ior_n_out
);

  // The timer counts down to zero, so each phase loads its length minus one.
  localparam logic [15:0] SETUP_LD = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] PULSE_LD = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] STD_LD   = 16'(STD_DELAY_CYCLES - 1);
  localparam logic [15:0] LONG_LD  = 16'(LONG_DELAY_CYCLES - 1);

  bus_state_e  state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [15:0] datar_q, datar_d;
  logic        datar_vld_q, datar_vld_d;
  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tmr_done;
  logic [15:0] dly_ld;
  logic        accept;

  enet_cycle_timer u_timer (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Ready also covers the last busy cycle: DAT_HOLD when no delay is selected, or the final POST_DELAY count.
  // A new command can therefore follow with no idle gap.
  always_comb begin
    rdy_out = (state_q == IDLE) ||
              (state_q == DAT_HOLD && cmd_q.dly == NO_DELAY) ||
              (state_q == POST_DELAY && tmr_done);
  end

  assign accept = rdy_out && start_comm_in;

  // Map the captured delay code to a counter preload.
  always_comb begin
    dly_ld = 16'd0;
    if (cmd_q.dly == STD_DELAY) begin
      dly_ld = STD_LD;
    end else if (cmd_q.dly >= LONG_DELAY) begin
      dly_ld = LONG_LD;
    end
  end

  // Next state and pin drive. The pins decode from state_q only, so an asynchronous reset releases them at once.
  always_comb begin
    state_d         = state_q;
    cmd_d           = cmd_q;
    datar_d         = datar_q;
    datar_vld_d     = 1'b0;
    tmr_load        = 1'b0;
    tmr_val         = SETUP_LD;
    enet_data_out   = 16'h0000;
    enet_data_oe    = 1'b0;
    enet_cmd_out    = INDEX;
    enet_cs_n_out   = 1'b1;
    enet_iow_n_out  = 1'b1;
    enet_ior_n_out  = 1'b1;

    case (state_q)
      IDX_SETUP, IDX_PULSE, IDX_HOLD: begin
        enet_cmd_out  = INDEX;
        enet_cs_n_out = 1'b0;
        enet_data_oe  = 1'b1;
        enet_data_out = {8'h00, cmd_q.addr};
      end
      DAT_SETUP, DAT_PULSE, DAT_HOLD: begin
        enet_cmd_out  = DATA;
        enet_cs_n_out = 1'b0;
        enet_data_oe  = cmd_q.write;
        enet_data_out = cmd_q.write ? cmd_q.dataw : 16'h0000;
      end
      default: ;
    endcase

    case (state_q)
      IDX_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
          state_d  = IDX_PULSE;
        end
      end
      IDX_PULSE: begin
        enet_iow_n_out = 1'b0;
        if (tmr_done) state_d = IDX_HOLD;
      end
      IDX_HOLD: begin
        tmr_load = 1'b1;
        tmr_val  = SETUP_LD;
        state_d  = DAT_SETUP;
      end
      DAT_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
          state_d  = DAT_PULSE;
        end
      end
      DAT_PULSE: begin
        enet_iow_n_out = !cmd_q.write;
        enet_ior_n_out = cmd_q.write;
        if (tmr_done) begin
          state_d = DAT_HOLD;
          // Sample the bus on the last strobe cycle, so the data is presented during DAT_HOLD.
          if (!cmd_q.write) begin
            datar_d     = enet_data_in;
            datar_vld_d = 1'b1;
          end
        end
      end
      DAT_HOLD: begin
        if (cmd_q.dly == NO_DELAY) begin
          state_d = IDLE;
        end else begin
          tmr_load = 1'b1;
          tmr_val  = dly_ld;
          state_d  = POST_DELAY;
        end
      end
      POST_DELAY: begin
        if (tmr_done) state_d = IDLE;
      end
      default: ;
    endcase

    // A new command is accepted only in a ready cycle, so this overrides the exit taken above.
    if (accept) begin
      cmd_d    = '{addr: addr_in, dataw: dataw_in, write: write_in, dly: post_command_delay_in};
      tmr_load = 1'b1;
      tmr_val  = SETUP_LD;
      state_d  = IDX_SETUP;
    end
  end

  // State, command and read-data registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      datar_q     <= 16'h0000;
      datar_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      datar_q     <= datar_d;
      datar_vld_q <= datar_vld_d;
    end
  end

  assign datar_out       = datar_q;
  assign datar_valid_out = datar_vld_q;

endmodule

// File: tb/tb_enet_bus_controller.sv
// Bench for enet_bus_controller. A command-level model predicts every pin for each cycle after the accept edge.
// Directed cases pin down the literal values, then a random phase runs against the same model.
module tb_enet_bus_controller;

  localparam int S    = 1;
  localparam int P    = 2;
  localparam int STD  = 16;
  localparam int LONG = 100;
  localparam int T    = 2 * (S + P + 1);
  localparam int H    = T / 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        start_comm_in = 1'b0;
  logic [7:0]  addr_in = 8'h00;
  logic [15:0] dataw_in = 16'h0000;
  logic        write_in = 1'b0;
  logic [2:0]  post_command_delay_in = 3'd0;
  logic [15:0] enet_data_in = 16'h0000;
  logic        rdy_out, datar_valid_out, enet_data_oe, enet_cmd_out;
  logic        enet_cs_n_out, enet_iow_n_out, enet_ior_n_out;
  logic [15:0] datar_out, enet_data_out;

  enet_bus_controller #(
    .SETUP_CYCLES(S), .PULSE_CYCLES(P), .STD_DELAY_CYCLES(STD), .LONG_DELAY_CYCLES(LONG)
  ) dut (
    .Clock(Clock), .Reset(Reset), .start_comm_in(start_comm_in), .addr_in(addr_in),
    .dataw_in(dataw_in), .write_in(write_in), .post_command_delay_in(post_command_delay_in),
    .rdy_out(rdy_out), .datar_out(datar_out), .datar_valid_out(datar_valid_out),
    .enet_data_in(enet_data_in), .enet_data_out(enet_data_out), .enet_data_oe(enet_data_oe),
    .enet_cmd_out(enet_cmd_out), .enet_cs_n_out(enet_cs_n_out),
    .enet_iow_n_out(enet_iow_n_out), .enet_ior_n_out(enet_ior_n_out)
  );

  always #5 Clock = ~Clock;

  // Model: a command in flight, plus how many cycles have passed since it was accepted.
  bit          m_busy = 1'b0;
  int          m_k = 0;
  int          m_d = 0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] m_dataw = 16'h0000;
  logic        m_wr = 1'b0;
  logic [15:0] m_datar = 16'h0000;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  function automatic int delay_of(input logic [2:0] c);
    if (c == 3'd0) return 0;
    if (c == 3'd1) return STD;
    return LONG;
  endfunction

  // Advance the model. Ready is high when idle and in the final cycle (T + D) of a command.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_busy  = 1'b0;
      m_k     = 0;
      m_datar = 16'h0000;
    end else begin
      if (m_busy && !m_wr && m_k == T - 1) m_datar = enet_data_in;
      if ((!m_busy || m_k == T + m_d) && start_comm_in) begin
        m_busy  = 1'b1;
        m_k     = 1;
        m_addr  = addr_in;
        m_dataw = dataw_in;
        m_wr    = write_in;
        m_d     = delay_of(post_command_delay_in);
      end else if (m_busy) begin
        if (m_k == T + m_d) m_busy = 1'b0;
        else m_k = m_k + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance one cycle to the falling edge and compare every output with the model.
  task automatic step();
    logic        e_rdy, e_cs, e_cmd, e_oe, e_iow, e_ior, e_vld, mask_d;
    logic [15:0] e_dout;
    logic [38:0] act, exp, msk;
    int j;
    @(negedge Clock);
    cyc++;
    e_rdy = !m_busy || (m_k == T + m_d);
    e_cs = 1'b1; e_cmd = 1'b0; e_oe = 1'b0; e_iow = 1'b1; e_ior = 1'b1;
    e_dout = 16'h0000; mask_d = 1'b0;
    if (m_busy && m_k <= H) begin
      j = m_k;
      e_cs = 1'b0; e_cmd = 1'b0; e_oe = 1'b1; e_dout = {8'h00, m_addr};
      e_iow = !(j > S && j <= S + P);
    end else if (m_busy && m_k <= T) begin
      j = m_k - H;
      e_cs = 1'b0; e_cmd = 1'b1; e_oe = m_wr;
      e_dout = m_dataw; mask_d = !m_wr;
      e_iow = !(m_wr && j > S && j <= S + P);
      e_ior = !(!m_wr && j > S && j <= S + P);
    end
    e_vld = m_busy && !m_wr && m_k == T;
    act = {rdy_out, enet_cs_n_out, enet_cmd_out, enet_data_oe, enet_iow_n_out, enet_ior_n_out,
           datar_valid_out, enet_data_out, datar_out};
    exp = {e_rdy, e_cs, e_cmd, e_oe, e_iow, e_ior, e_vld, e_dout, m_datar};
    msk = '1;
    if (mask_d) msk[31:16] = 16'h0000;
    n_cmp++;
    if ((act & msk) !== (exp & msk)) begin
      n_bad++;
      $display("FAIL pins cyc=%0d got %h expected %h", cyc, act & msk, exp & msk);
    end
  endtask

  // Wait at falling edges (bounded) until ready, then drive a command that is taken at the next rising edge.
  // Returns at the falling edge of cycle 1 after the accept edge.
  task automatic issue(input logic [7:0] a, input logic [15:0] d, input logic w, input logic [2:0] c,
                       output int waited);
    waited = 0;
    while (rdy_out !== 1'b1 && waited < 600) begin
      step();
      waited++;
    end
    if (rdy_out !== 1'b1) chk("rdy_timeout", 32'(rdy_out), 32'd1);
    addr_in = a; dataw_in = d; write_in = w; post_command_delay_in = c;
    start_comm_in = 1'b1;
    step();
    start_comm_in = 1'b0;
  endtask

  initial begin
    int w, cnt_a, cnt_b, cnt_c, t0, r;

    // Reset state.
    step(); step();
    chk("rst_rdy", 32'(rdy_out), 32'd1);
    chk("rst_pins", {27'd0, enet_cs_n_out, enet_iow_n_out, enet_ior_n_out, enet_cmd_out, enet_data_oe},
        32'b11100);
    chk("rst_dout", 32'(enet_data_out), 32'h0);
    chk("rst_datar", {15'd0, datar_valid_out, datar_out}, 32'h0);
    Reset = 1'b0;
    step(); step();

    // Write 0x00AA to register 0x1F with no delay.
    issue(8'h1F, 16'h00AA, 1'b1, 3'd0, w);
    cnt_a = 0; cnt_b = 0;
    for (int n = 1; n <= T; n++) begin
      if (n > 1) step();
      if (n == 1) chk("wr_rdy_c1", 32'(rdy_out), 32'd0);
      if (n == 2) chk("wr_idx_c2", {15'd0, enet_cmd_out, enet_data_out}, 32'h0000_001F);
      if (n == 6) chk("wr_dat_c6", {15'd0, enet_cmd_out, enet_data_out}, 32'h0001_00AA);
      if (n == 7) chk("wr_rdy_c7", 32'(rdy_out), 32'd0);
      if (n == 8) chk("wr_rdy_c8", 32'(rdy_out), 32'd1);
      if (!enet_iow_n_out && !enet_cmd_out && enet_data_out == 16'h001F) cnt_a++;
      if (!enet_iow_n_out && enet_cmd_out && enet_data_out == 16'h00AA) cnt_b++;
    end
    chk("wr_idx_pulse", 32'(cnt_a), 32'd2);
    chk("wr_dat_pulse", 32'(cnt_b), 32'd2);

    // Read register 0x28 while the bus returns 0x0A46.
    enet_data_in = 16'h0A46;
    issue(8'h28, 16'h0000, 1'b0, 3'd0, w);
    cnt_a = 0; cnt_b = 0;
    for (int n = 1; n <= T; n++) begin
      if (n > 1) step();
      if (!enet_ior_n_out && !enet_data_oe) cnt_a++;
      if (!enet_ior_n_out && !enet_iow_n_out) cnt_b++;
      if (n == 7) chk("rd_vld_c7", 32'(datar_valid_out), 32'd0);
      if (n == 8) chk("rd_c8", {15'd0, datar_valid_out, datar_out}, 32'h0001_0A46);
    end
    chk("rd_pulse", 32'(cnt_a), 32'd2);
    chk("rd_overlap", 32'(cnt_b), 32'd0);
    step();
    chk("rd_hold", {15'd0, datar_valid_out, datar_out}, 32'h0000_0A46);

    // Delay codes 1, 2 and 5.
    for (int i = 0; i < 3; i++) begin
      logic [2:0] code;
      int dl;
      code = (i == 0) ? 3'd1 : (i == 1) ? 3'd2 : 3'd5;
      dl = (i == 0) ? 24 : 108;
      issue(8'h05, 16'h1111, 1'b1, code, w);
      for (int n = 1; n <= dl; n++) begin
        if (n > 1) step();
        if (n == dl - 1) chk("dly_rdy_early", 32'(rdy_out), 32'd0);
        if (n == dl) chk("dly_rdy_back", {29'd0, code}, rdy_out ? {29'd0, code} : 32'hFFFF_FFFF);
      end
    end

    // Start pulses while busy are ignored.
    issue(8'h03, 16'h0033, 1'b1, 3'd0, w);
    cnt_a = 0; cnt_b = 0;
    for (int n = 1; n <= 16; n++) begin
      if (n > 1) step();
      if (n == 3 || n == 7) begin
        addr_in = 8'hEE; start_comm_in = 1'b1;
      end else begin
        start_comm_in = 1'b0;
      end
      if (n == 2) chk("busy_idx_addr", 32'(enet_data_out), 32'h0003);
      if (!enet_iow_n_out) cnt_a++;
      if (n > T && !enet_cs_n_out) cnt_b++;
    end
    chk("busy_strobes", 32'(cnt_a), 32'd4);
    chk("busy_no_second", 32'(cnt_b), 32'd0);

    // Asynchronous reset during the data write strobe.
    issue(8'h55, 16'h1234, 1'b1, 3'd1, w);
    for (int n = 2; n <= 6; n++) step();
    chk("ar_pulse_before", 32'(enet_iow_n_out), 32'd0);
    #1 Reset = 1'b1;
    #1;
    chk("ar_pins", {28'd0, enet_iow_n_out, enet_cs_n_out, enet_data_oe, rdy_out}, 32'b1101);
    step(); step();
    Reset = 1'b0;
    step();
    issue(8'h10, 16'hBEEF, 1'b1, 3'd0, w);
    for (int n = 2; n <= T; n++) begin
      step();
      if (n == 6) chk("ar_fresh_dat", 32'(enet_data_out), 32'h0000_BEEF);
      if (n == 8) chk("ar_fresh_rdy", 32'(rdy_out), 32'd1);
    end

    // Thirteen back-to-back writes.
    cnt_a = 0; cnt_b = 0; cnt_c = 0; t0 = 0;
    for (int i = 0; i < 13; i++) begin
      issue(8'(i), 16'($urandom), 1'b1, 3'd0, w);
      if (i == 0) t0 = cyc;
      cnt_c += w;
      for (int n = 1; n <= T; n++) begin
        if (n > 1) step();
        if (!enet_iow_n_out) cnt_a++;
        if (!enet_cs_n_out) cnt_b++;
      end
    end
    chk("b2b_span", 32'(cyc - t0 + 1), 32'd104);
    chk("b2b_strobes", 32'(cnt_a), 32'd52);
    chk("b2b_cs_low", 32'(cnt_b), 32'd104);
    chk("b2b_waits", 32'(cnt_c), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step();
      enet_data_in  = 16'($urandom);
      start_comm_in = ($urandom_range(0, 2) == 0);
      addr_in       = 8'($urandom);
      dataw_in      = 16'($urandom);
      write_in      = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 15);
      post_command_delay_in = (r < 10) ? 3'd0 : (r < 14) ? 3'd1 : 3'($urandom_range(2, 7));
    end
    start_comm_in = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/enet_bus_controller.md
# enet_bus_controller

Register-level bus controller for the DM9000A Ethernet MAC/PHY; sits directly downstream of the init sequencer and packet engines, behind the access arbiter. It turns one command into a DM9000A index cycle plus data cycle:
- write: register address, then data write;
- read: register address, then data read.

After the bus cycles it holds off for a programmable post-command delay, and it signals readiness so the next command can be issued.

## Interface
Parameters:
- SETUP_CYCLES, 1: cycles CMD/data are driven before a strobe falls (≥1)
- PULSE_CYCLES, 2: cycles IOW_N/IOR_N held low (≥1)
- STD_DELAY_CYCLES, 16: post-command delay for code STD (16-bit)
- LONG_DELAY_CYCLES, 50000: post-command delay for code LONG (16-bit)

Ports (one clock; reset is asynchronous and active-high):
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- start_comm_in  in  1  one-cycle command strobe; honoured only while rdy_out=1
- addr_in  in  8  DM9000A register index
- dataw_in  in  16  write data
- write_in  in  1  1=write, 0=read
- post_command_delay_in  in  3  0=NONE, 1=STD, 2..7=LONG
- rdy_out  out  1  idle and able to accept a command
- datar_out  out  16  last read data
- datar_valid_out  out  1  one-cycle pulse when datar_out updates
- enet_data_in  in  16  DM9000A data bus, input side
- enet_data_out  out  16  DM9000A data bus, output side
- enet_data_oe  out  1  tristate enable for enet_data_out
- enet_cmd_out  out  1  DM9000A CMD pin: 0=index, 1=data
- enet_cs_n_out  out  1  chip select, active low
- enet_iow_n_out  out  1  write strobe, active low
- enet_ior_n_out  out  1  read strobe, active low

## Operation
- **States:** IDLE, IDX_SETUP, IDX_PULSE, IDX_HOLD, DAT_SETUP, DAT_PULSE, DAT_HOLD, POST_DELAY.
- **IDLE:** rdy_out=1; all pins inactive.
  - start_comm_in=1 captures addr/dataw/write/delay code into registers → IDX_SETUP.
- **Index phase (IDX_SETUP, IDX_PULSE, IDX_HOLD):**
  - cmd=0, cs_n=0, oe=1, data_out={8'h00, addr}.
  - iow_n=0 only in IDX_PULSE.
- **Data phase (DAT_SETUP, DAT_PULSE, DAT_HOLD):**
  - cmd=1, cs_n=0.
  - Write: oe=1, data_out=dataw, iow_n=0 in DAT_PULSE.
  - Read: oe=0, ior_n=0 in DAT_PULSE.
- **Read sampling:** enet_data_in is sampled on the last DAT_PULSE cycle. datar_out updates and datar_valid_out pulses during DAT_HOLD. datar_out holds its value otherwise; a write never changes it.
- **After DAT_HOLD:**
  - delay code 0 → IDLE.
  - otherwise → POST_DELAY, which counts down STD_DELAY_CYCLES or LONG_DELAY_CYCLES, then → IDLE. Pins are inactive during POST_DELAY.
- start_comm_in while rdy_out=0 is ignored, with no queuing.
- Strobes never overlap. cs_n stays low continuously from IDX_SETUP through DAT_HOLD.

## Timing
- **Reset values:**
  - rdy_out=1
  - cs_n, iow_n, ior_n = 1
  - cmd=0, oe=0, data_out=0
  - datar_out=0, datar_valid_out=0
  - state=IDLE, counter=0
- **Reset mid-operation:** takes effect immediately (asynchronous); strobes deassert without waiting for a clock edge. The command in progress is abandoned.
- **Bus-cycle length:** T = 2*(SETUP_CYCLES + PULSE_CYCLES + 1); with defaults T = 8.
- **Accept edge:** E0 is the edge at which start_comm_in=1 is sampled in IDLE.
  - rdy_out drops in the cycle after E0.
  - rdy_out is high again T+D cycles after E0, where D ∈ {0, STD_DELAY_CYCLES, LONG_DELAY_CYCLES}.
- **Read data:** datar_valid_out is high exactly in cycle T after E0 (the DAT_HOLD cycle).
- **Next command:** may be accepted on the same edge that rdy_out is seen high.
- **Delay counter:** 16-bit down-counter, loaded with D−1 on entry to POST_DELAY; exits when the count reaches 0. No wrap.

## Structure
- **Package enet_pkg holds:**
  - delay-code constants NO_DELAY=3'd0, STD_DELAY=3'd1, LONG_DELAY=3'd2;
  - the bus-state enum;
  - the CMD encodings INDEX=1'b0, DATA=1'b1.
- **Sub-module enet_cycle_timer:** one loadable 16-bit down-counter with a `done` flag. It is reused for setup, pulse and post-delay counting.
- The tristate buffer lives at top level, outside this block.

## Test plan
- **Write:** reset, then addr=8'h1F, dataw=16'h00AA, write=1, delay=0 → pin sequence:
  - cmd=0 with data_out=16'h001F and iow_n low for 2 cycles;
  - then cmd=1 with data_out=16'h00AA and iow_n low for 2 cycles;
  - rdy_out high 8 cycles after E0.
- **Read:** addr=8'h28, write=0, enet_data_in=16'h0A46 → ior_n low for 2 cycles with oe=0; datar_out=16'h0A46 and datar_valid_out high in cycle 8; ior_n never overlaps iow_n.
- **Delays:** delay=1 with STD_DELAY_CYCLES=16 → rdy_out returns at cycle 24. delay=2 with LONG_DELAY_CYCLES=100 → rdy_out returns at cycle 108. delay=5 behaves as LONG.
- **Busy:** start_comm_in pulsed at cycles 3 and 7 of a command → ignored; exactly one index/data pair appears on the pins.
- **Async reset:** assert Reset during DAT_PULSE of a write → iow_n, cs_n and oe go inactive without a clock edge; rdy_out=1; a fresh command then completes normally.
- **Back-to-back:** thirteen back-to-back writes driven as soon as rdy_out is seen high → 13 complete pin sequences, no gaps beyond the programmed delays.
